vote_ctrl: RTL
==============

VOTE_CTRL -- requirements
Module: vote_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_CYC, default 1000, which sets the voting window length in clock cycles (legal range 1..65535).
REQ-002 The block SHALL have parameter SHOW_CYC, default 500, which sets the result-display lockout length in clock cycles (legal range 1..65535).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is a synchronous, active-low reset.
REQ-005 Port start  input  1  is a request to open a voting round; it is level-sampled.
REQ-006 Port vote  input  5  carries the voter inputs; bit i is voter i, and 1 means yes.
REQ-007 Port voting  output  1  is high while the voting window is open.
REQ-008 Port voted  output  5  holds the sticky per-voter yes flags for the current or last round.
REQ-009 Port yes_cnt  output  3  is the number of yes votes, 0..5.
REQ-010 Port pass  output  1  indicates a majority result: yes_cnt >= 3.
REQ-011 Port fail  output  1  indicates a minority result: yes_cnt <= 2.
REQ-012 Port done  output  1  is a one-cycle pulse marking the cycle in which the result becomes valid.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, VOTE, TALLY and SHOW.
REQ-014 In IDLE with start=1, the FSM SHALL enter VOTE on the next edge; on that same edge voted, yes_cnt, pass, fail and the window counter SHALL clear to 0.
REQ-015 In IDLE with start=0, the FSM SHALL remain in IDLE and all outputs SHALL hold.
REQ-016 In VOTE, voting SHALL be 1; in every other state it SHALL be 0.
REQ-017 In VOTE, each edge SHALL load voted <= voted | vote; a set bit SHALL stay set until the next round starts, with no retraction.
REQ-018 In VOTE, the window counter SHALL increment by 1 per cycle, starting at 0 on the first VOTE cycle.
REQ-019 VOTE SHALL exit to TALLY on the edge where the counter equals WIN_CYC-1 (timeout) or (voted | vote) == 5'b11111 (early close), whichever happens first; if both hold in the same cycle, the result is the same transition.
REQ-020 For WIN_CYC=1, VOTE SHALL last exactly one cycle.
REQ-021 TALLY SHALL last exactly one cycle; on its exit edge it SHALL load yes_cnt <= popcount(voted), pass <= (popcount >= 3), fail <= (popcount < 3), and the FSM SHALL enter SHOW.
REQ-022 done SHALL be 1 only in the first SHOW cycle, and pass/fail/yes_cnt SHALL already be valid in that cycle.
REQ-023 pass and fail SHALL never both be 1; both SHALL be 0 from reset and from round start until the tally completes.
REQ-024 SHOW SHALL last exactly SHOW_CYC cycles and then return to IDLE; pass, fail, yes_cnt and voted SHALL hold through SHOW and IDLE until the next start is accepted.
REQ-025 start SHALL be ignored in VOTE, TALLY and SHOW, and has no queuing effect; start held high through SHOW SHALL begin a new round on the first IDLE cycle, with one IDLE cycle minimum between rounds.
REQ-026 vote SHALL be ignored outside VOTE.
REQ-027 The latency from start sampled high in IDLE to the first done SHALL be at most WIN_CYC+2 cycles.
REQ-028 Counters SHALL be 16 bits wide and SHALL never wrap, because the exit comparisons precede any overflow.

Reset
REQ-029 With rst_n=0 at an edge, the state SHALL become IDLE and voting, voted, yes_cnt, pass, fail, done and both counters SHALL become 0, regardless of the current state.
REQ-030 Reset asserted mid-VOTE or mid-SHOW SHALL abort the round with no done pulse, and the outputs SHALL read 0 on the following cycle.
REQ-031 After rst_n returns high, the block SHALL require start=1 to begin a round.

Verification (WIN_CYC=8, SHOW_CYC=4)
REQ-032 Timeout majority: start pulse; vote=5'b00111 on VOTE cycle 2, then vote=0. Expected: VOTE lasts 8 cycles, then yes_cnt=3, pass=1, fail=0, done lasts 1 cycle, SHOW lasts 4 cycles, then IDLE.
REQ-033 Early close: vote=5'b10101 on cycle 0, then 5'b01010 on cycle 3. Expected: TALLY follows cycle 3 (VOTE is 4 cycles), yes_cnt=5, pass=1.
REQ-034 Sticky minority: voter 4 pulses three times and voter 0 pulses once, with no other votes. Expected: voted=5'b10001, yes_cnt=2, fail=1, pass=0.
REQ-035 Ignored inputs: start and vote=5'b11111 toggled during SHOW. Expected: no new round starts, outputs hold, and there is exactly one done pulse per round.
REQ-036 Reset abort: rst_n=0 for one cycle at VOTE cycle 5. Expected: the next cycle is IDLE with all outputs 0, no done pulse, and a new start runs a full 8-cycle window.
REQ-037 Back-to-back rounds: start held high continuously. Expected: a new round begins one IDLE cycle after each SHOW, and voted/pass clear on each round entry.

Source files
------------

// File: rtl/vote_ctrl.sv
// Five-voter round controller: opens a timed voting window, tallies the sticky yes flags,
// then shows the majority/minority result for a fixed lockout before accepting a new round.
module vote_ctrl #(
  parameter int unsigned WIN_CYC  = 1000,
  parameter int unsigned SHOW_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] vote,
  output logic       voting,
  output logic [4:0] voted,
  output logic [2:0] yes_cnt,
  output logic       pass,
  output logic       fail,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StVote, StTally, StShow} state_e;

  localparam logic [15:0] WinLast  = 16'(WIN_CYC - 1);
  localparam logic [15:0] ShowLast = 16'(SHOW_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [15:0] show_cnt_q, show_cnt_d;
  logic [4:0]  voted_q, voted_d;
  logic [2:0]  yes_cnt_q, yes_cnt_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        done_q, done_d;
  logic [4:0]  vote_acc;
  logic [2:0]  ones;

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    show_cnt_d = show_cnt_q;
    voted_d    = voted_q;
    yes_cnt_d  = yes_cnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    done_d     = 1'b0;
    // Early close looks at this cycle's votes too, not just the registered flags.
    vote_acc   = voted_q | vote;
    ones       = 3'd0;
    for (int i = 0; i < 5; i++) begin
      ones = ones + {2'b00, voted_q[i]};
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StVote;
          win_cnt_d = 16'd0;
          voted_d   = 5'd0;
          yes_cnt_d = 3'd0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
        end
      end
      StVote: begin
        voted_d   = vote_acc;
        win_cnt_d = win_cnt_q + 16'd1;
        if ((win_cnt_q == WinLast) || (vote_acc == 5'b11111)) begin
          state_d = StTally;
        end
      end
      StTally: begin
        yes_cnt_d  = ones;
        pass_d     = (ones >= 3'd3);
        fail_d     = (ones < 3'd3);
        done_d     = 1'b1;
        show_cnt_d = 16'd0;
        state_d    = StShow;
      end
      StShow: begin
        show_cnt_d = show_cnt_q + 16'd1;
        if (show_cnt_q == ShowLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      win_cnt_q  <= 16'd0;
      show_cnt_q <= 16'd0;
      voted_q    <= 5'd0;
      yes_cnt_q  <= 3'd0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      show_cnt_q <= show_cnt_d;
      voted_q    <= voted_d;
      yes_cnt_q  <= yes_cnt_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      done_q     <= done_d;
    end
  end

  assign voting  = (state_q == StVote);
  assign voted   = voted_q;
  assign yes_cnt = yes_cnt_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign done    = done_q;

endmodule
